// File: rtl/clock_divider_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// clock_divider_ctrl
//
// Purpose:
//   Runtime-controlled clock divider for the LCD/text pipeline. It starts and
//   stops a divided clock on request and accepts new half-period values over a
//   valid/ready handshake. A new value takes effect only at a low-to-high toggle
//   of o_clk or when the divider stops, so o_clk never shows a runt phase.
//
// Parameters:
//   CNT_WIDTH     width of the half-period counter and divisor value
//   DEFAULT_HALF  half-period (i_clk cycles) in force after reset
//
// Ports:
//   i_clk          system clock, all logic on posedge
//   i_rst          asynchronous active-high reset
//   i_en           run request (level)
//   i_cfg_valid    new half-period offered
//   i_cfg_half     requested half-period; 0 is treated as 1
//   o_cfg_ready    controller can accept a half-period (no value pending)
//   o_clk          divided clock, registered
//   o_rise         one-cycle pulse in the first cycle of each o_clk high phase
//   o_fall         one-cycle pulse in the first cycle of each o_clk low phase
//   o_running      high while in RUN or DRAIN
//   o_active_half  half-period currently in force
//   o_rise_count   (CLOCK_DIVIDER_CTRL_RISE_COUNT_EN only) o_rise pulses since
//                  reset or the last divisor load
//
// Optional feature macro: CLOCK_DIVIDER_CTRL_RISE_COUNT_EN
// -----------------------------------------------------------------------------
module clock_divider_ctrl #(
  parameter int CNT_WIDTH    = 16,
  parameter int DEFAULT_HALF = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_cfg_valid,
  input  logic [CNT_WIDTH-1:0] i_cfg_half,
  output logic                 o_cfg_ready,
  output logic                 o_clk,
  output logic                 o_rise,
  output logic                 o_fall,
  output logic                 o_running,
  output logic [CNT_WIDTH-1:0] o_active_half
`ifdef CLOCK_DIVIDER_CTRL_RISE_COUNT_EN
  ,
  output logic [31:0]          o_rise_count
`endif
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] DEFAULT_HALF_C = CNT_WIDTH'(DEFAULT_HALF);
  localparam logic [CNT_WIDTH-1:0] ONE_C          = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 clk_q, clk_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [CNT_WIDTH-1:0] active_half_q, active_half_d;
  logic                 pend_q, pend_d;
  logic [CNT_WIDTH-1:0] pend_half_q, pend_half_d;

  logic                 accept;
  logic [CNT_WIDTH-1:0] half_clamped;
  logic                 at_limit;
  logic                 rise_now;
  logic                 stop_now;
  logic                 div_load;   // a new divisor takes effect at this edge

  assign accept       = i_cfg_valid && !pend_q;
  assign half_clamped = (i_cfg_half == '0) ? ONE_C : i_cfg_half;
  // active_half_q is never 0, so this compare fires before the counter can wrap.
  assign at_limit     = (cnt_q == active_half_q - ONE_C);

  // NOTE: every variable written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    clk_d         = clk_q;
    rise_d        = 1'b0;
    fall_d        = 1'b0;
    active_half_d = active_half_q;
    pend_d        = pend_q;
    pend_half_d   = pend_half_q;
    rise_now      = 1'b0;
    stop_now      = 1'b0;
    div_load      = 1'b0;

    case (state_q)
      ST_STOP: begin
        cnt_d = '0;
        clk_d = 1'b0;
        // In STOP there is no phase to protect, so the value loads directly.
        if (accept) begin
          active_half_d = half_clamped;
          div_load      = 1'b1;
        end
        if (i_en) state_d = ST_RUN;
      end

      ST_RUN, ST_DRAIN: begin
        if (accept) begin
          pend_d      = 1'b1;
          pend_half_d = half_clamped;
        end

        if (state_q == ST_RUN && !i_en && !clk_q) begin
          // Stop request during the low phase: the stop wins over any rise.
          stop_now = 1'b1;
        end else if (at_limit) begin
          cnt_d = '0;
          clk_d = !clk_q;
          if (clk_q) begin
            fall_d = 1'b1;
            // High phase completes here; a stop request ends the run now.
            if (state_q == ST_DRAIN || !i_en) stop_now = 1'b1;
          end else begin
            rise_d   = 1'b1;
            rise_now = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE_C;
          // Stop request mid high phase: let the high phase finish in DRAIN.
          if (state_q == ST_RUN && !i_en) state_d = ST_DRAIN;
        end

        if (stop_now) begin
          state_d = ST_STOP;
          cnt_d   = '0;
          clk_d   = 1'b0;
        end

        if ((rise_now || stop_now) && pend_q) begin
          active_half_d = pend_half_q;
          pend_d        = 1'b0;
          div_load      = 1'b1;
        end else if (stop_now && accept) begin
          // A value offered on the stopping edge is applied at once rather
          // than left pending while stopped.
          active_half_d = half_clamped;
          pend_d        = 1'b0;
          div_load      = 1'b1;
        end
      end

      default: begin
        state_d = ST_STOP;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_STOP;
      cnt_q         <= '0;
      clk_q         <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      active_half_q <= DEFAULT_HALF_C;
      pend_q        <= 1'b0;
      pend_half_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      clk_q         <= clk_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      active_half_q <= active_half_d;
      pend_q        <= pend_d;
      pend_half_q   <= pend_half_d;
    end
  end

  assign o_cfg_ready   = !pend_q;
  assign o_clk         = clk_q;
  assign o_rise        = rise_q;
  assign o_fall        = fall_q;
  assign o_running     = (state_q != ST_STOP);
  assign o_active_half = active_half_q;

`ifdef CLOCK_DIVIDER_CTRL_RISE_COUNT_EN
  logic [31:0] rise_cnt_q, rise_cnt_d;

  // A divisor load clears the count even when that edge also raises o_rise.
  always_comb begin
    rise_cnt_d = rise_cnt_q;
    if (div_load)    rise_cnt_d = '0;
    else if (rise_d) rise_cnt_d = rise_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rise_cnt_q <= '0;
    else       rise_cnt_q <= rise_cnt_d;
  end

  assign o_rise_count = rise_cnt_q;
`endif

endmodule
